// File: rtl/alu_issue_stage.sv
// Issue/retire wrapper around the 32-bit ripple ALU. It registers one operation onto the ALU
// inputs, waits SETTLE_CYCLES edges for propagation, then holds the captured result on a valid/ready port.
module alu_issue_stage #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_opA,
    input  logic [31:0]      in_opB,
    input  logic [2:0]       in_cmd,
    output logic [31:0]      alu_operandA,
    output logic [31:0]      alu_operandB,
    output logic [2:0]       alu_command,
    input  logic [31:0]      alu_result,
    input  logic             alu_carryout,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_carryout,
    output logic             out_zero,
    output logic             out_overflow,
    output logic [2:0]       out_cmd,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t             state_reg;
    logic [7:0]         settle_cnt_reg;
    logic [31:0]        opa_reg;
    logic [31:0]        opb_reg;
    logic [2:0]         cmd_reg;
    logic [31:0]        res_reg;
    logic               carry_reg;
    logic               zero_reg;
    logic               ovf_reg;
    logic [2:0]         out_cmd_reg;
    logic               out_valid_reg;
    logic               busy_reg;
    logic [CNT_W-1:0]   op_count_reg;

    logic               accept;
    logic               out_fire;

    // A result leaving DONE frees the ALU on the same edge, so a waiting operation loads without a bubble.
    assign in_ready = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign out_fire = (state_reg == DONE) && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            settle_cnt_reg <= 8'd0;
            opa_reg        <= 32'd0;
            opb_reg        <= 32'd0;
            cmd_reg        <= 3'd0;
            res_reg        <= 32'd0;
            carry_reg      <= 1'b0;
            zero_reg       <= 1'b0;
            ovf_reg        <= 1'b0;
            out_cmd_reg    <= 3'd0;
            out_valid_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            op_count_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        opa_reg        <= in_opA;
                        opb_reg        <= in_opB;
                        cmd_reg        <= in_cmd;
                        settle_cnt_reg <= SETTLE_LOAD;
                        busy_reg       <= 1'b1;
                        state_reg      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt_reg == 8'd0) begin
                        res_reg       <= alu_result;
                        carry_reg     <= alu_carryout;
                        zero_reg      <= alu_zero;
                        ovf_reg       <= alu_overflow;
                        out_cmd_reg   <= cmd_reg;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg - 8'd1;
                    end
                end
                DONE: begin
                    if (out_fire) begin
                        op_count_reg  <= op_count_reg + CNT_W'(1);
                        out_valid_reg <= 1'b0;
                        if (in_valid) begin
                            opa_reg        <= in_opA;
                            opb_reg        <= in_opB;
                            cmd_reg        <= in_cmd;
                            settle_cnt_reg <= SETTLE_LOAD;
                            state_reg      <= SETTLE;
                        end else begin
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign alu_operandA = opa_reg;
    assign alu_operandB = opb_reg;
    assign alu_command  = cmd_reg;
    assign out_valid    = out_valid_reg;
    assign out_result   = res_reg;
    assign out_carryout = carry_reg;
    assign out_zero     = zero_reg;
    assign out_overflow = ovf_reg;
    assign out_cmd      = out_cmd_reg;
    assign busy         = busy_reg;
    assign op_count     = op_count_reg;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: a vector table through the default instance plus
// backpressure, back-to-back, mid-settle reset and counter-wrap sequences.
module tb_alu_issue_stage;

    localparam int SC = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;

    // default instance (SETTLE_CYCLES=4, CNT_W=16)
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] in_opA, in_opB, alu_operandA, alu_operandB, alu_result, out_result;
    logic [2:0]  in_cmd, alu_command, out_cmd;
    logic        alu_carryout, alu_zero, alu_overflow, out_carryout, out_zero, out_overflow;
    logic [15:0] op_count;

    // wrap instance (SETTLE_CYCLES=1, CNT_W=4)
    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_busy;
    logic [31:0] w_in_opA, w_in_opB, w_alu_operandA, w_alu_operandB, w_alu_result, w_out_result;
    logic [2:0]  w_in_cmd, w_alu_command, w_out_cmd;
    logic        w_alu_carryout, w_alu_zero, w_alu_overflow, w_out_carryout, w_out_zero, w_out_overflow;
    logic [3:0]  w_op_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference ALU: returns {carryout, zero, overflow, result}
    function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] c);
        logic [32:0] s;
        logic [31:0] r;
        logic co, ov;
        s = 33'd0; r = 32'd0; co = 1'b0; ov = 1'b0;
        case (c)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b}; r = s[31:0]; co = s[32];
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; co = s[32];
                ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'd2: r = a ^ b;
            3'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd4: r = a & b;
            3'd5: r = ~(a & b);
            3'd6: r = ~(a | b);
            default: r = a | b;
        endcase
        return {co, (r == 32'd0), ov, r};
    endfunction

    logic [34:0] alu0_bus, alu1_bus;
    always_comb alu0_bus = alu_model(alu_operandA, alu_operandB, alu_command);
    always_comb alu1_bus = alu_model(w_alu_operandA, w_alu_operandB, w_alu_command);
    assign {alu_carryout, alu_zero, alu_overflow, alu_result} = alu0_bus;
    assign {w_alu_carryout, w_alu_zero, w_alu_overflow, w_alu_result} = alu1_bus;

    alu_issue_stage #(.SETTLE_CYCLES(SC), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opA(in_opA), .in_opB(in_opB), .in_cmd(in_cmd),
        .alu_operandA(alu_operandA), .alu_operandB(alu_operandB), .alu_command(alu_command),
        .alu_result(alu_result), .alu_carryout(alu_carryout),
        .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_carryout(out_carryout),
        .out_zero(out_zero), .out_overflow(out_overflow),
        .out_cmd(out_cmd), .busy(busy), .op_count(op_count)
    );

    alu_issue_stage #(.SETTLE_CYCLES(1), .CNT_W(4)) dut_wrap (
        .clk(clk), .reset_n(reset_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_opA(w_in_opA), .in_opB(w_in_opB), .in_cmd(w_in_cmd),
        .alu_operandA(w_alu_operandA), .alu_operandB(w_alu_operandB), .alu_command(w_alu_command),
        .alu_result(w_alu_result), .alu_carryout(w_alu_carryout),
        .alu_zero(w_alu_zero), .alu_overflow(w_alu_overflow),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_result(w_out_result), .out_carryout(w_out_carryout),
        .out_zero(w_out_zero), .out_overflow(w_out_overflow),
        .out_cmd(w_out_cmd), .busy(w_busy), .op_count(w_op_count)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  cmd;
        logic [31:0] res;
        logic        c;
        logic        z;
        logic        v;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full transaction through the default instance with out_ready held high.
    task automatic run_vec(input vec_t v);
        int edges;
        logic [15:0] cnt_before;
        out_ready = 1'b1;
        in_valid = 1'b1; in_opA = v.a; in_opB = v.b; in_cmd = v.cmd;
        tick();
        in_valid = 1'b0;
        chk("alu_operandA", alu_operandA, v.a);
        chk("alu_operandB", alu_operandB, v.b);
        chk("alu_command", {29'd0, alu_command}, {29'd0, v.cmd});
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        chk("in_ready_settle", {31'd0, in_ready}, 32'd0);
        edges = 0;
        while (!out_valid && edges < 40) begin
            tick();
            edges++;
        end
        chk("latency", edges, SC);
        chk("out_result", out_result, v.res);
        chk("out_carryout", {31'd0, out_carryout}, {31'd0, v.c});
        chk("out_zero", {31'd0, out_zero}, {31'd0, v.z});
        chk("out_overflow", {31'd0, out_overflow}, {31'd0, v.v});
        chk("out_cmd", {29'd0, out_cmd}, {29'd0, v.cmd});
        cnt_before = op_count;
        tick();
        chk("op_count_inc", {16'd0, op_count}, {16'd0, cnt_before + 16'd1});
        chk("out_valid_fall", {31'd0, out_valid}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        $display("op cmd=%0d a=%h b=%h -> res=%h c=%0b z=%0b v=%0b count=%0d",
                 v.cmd, v.a, v.b, out_result, out_carryout, out_zero, out_overflow, op_count);
    endtask

    initial begin
        vecs[0] = '{32'd5,        32'd7,        3'd0, 32'd12,       1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'd3,        32'd3,        3'd1, 32'd0,        1'b1, 1'b1, 1'b0};
        vecs[2] = '{32'h7FFFFFFF, 32'd1,        3'd0, 32'h80000000, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{32'd0,        32'd1,        3'd1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'hF0F0F0F0, 32'hFFFF0000, 3'd4, 32'hF0F00000, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3'd5, 32'd0,        1'b0, 1'b1, 1'b0};
        vecs[6] = '{32'd0,        32'd0,        3'd6, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{32'hFFFFFFFF, 32'd1,        3'd3, 32'd1,        1'b0, 1'b0, 1'b0};

        reset_n = 1'b0;
        in_valid = 1'b0; in_opA = 32'd0; in_opB = 32'd0; in_cmd = 3'd0; out_ready = 1'b1;
        w_in_valid = 1'b0; w_in_opA = 32'd0; w_in_opB = 32'd0; w_in_cmd = 3'd0; w_out_ready = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;

        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_op_count", {16'd0, op_count}, 32'd0);
        chk("rst_alu_operandA", alu_operandA, 32'd0);
        chk("rst_out_result", out_result, 32'd0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Backpressure: SLT result must hold while out_ready is low and a new op waits.
        out_ready = 1'b0;
        in_valid = 1'b1; in_opA = 32'hFFFFFFFF; in_opB = 32'd1; in_cmd = 3'd3;
        tick();
        in_opA = 32'd9; in_opB = 32'd9; in_cmd = 3'd0;
        repeat (SC) tick();
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_result", out_result, 32'd1);
        begin
            logic [15:0] cnt0;
            cnt0 = op_count;
            for (int k = 0; k < 10; k++) begin
                tick();
                chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
                chk("bp_hold_result", out_result, 32'd1);
                chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
                chk("bp_alu_operandA", alu_operandA, 32'hFFFFFFFF);
                chk("bp_op_count", {16'd0, op_count}, {16'd0, cnt0});
            end
            $display("op backpressure held 10 cycles, result=%h count=%0d", out_result, op_count);
            out_ready = 1'b1;
            #1;
            chk("bp_in_ready_comb", {31'd0, in_ready}, 32'd1);
            tick();
            chk("bp_op_count_inc", {16'd0, op_count}, {16'd0, cnt0 + 16'd1});
            chk("bp_new_operandA", alu_operandA, 32'd9);
            chk("bp_valid_fall", {31'd0, out_valid}, 32'd0);
            chk("bp_busy", {31'd0, busy}, 32'd1);
        end
        in_valid = 1'b0;
        repeat (SC) tick();
        chk("bp_second_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_second_result", out_result, 32'd18);
        $display("op after backpressure cmd=0 a=9 b=9 -> res=%h", out_result);
        tick();

        // Back-to-back: XOR then OR with in_valid held high.
        in_valid = 1'b1; in_opA = 32'hF0F0F0F0; in_opB = 32'hFFFF0000; in_cmd = 3'd2;
        tick();
        in_opA = 32'd1; in_opB = 32'd2; in_cmd = 3'd7;
        repeat (SC - 1) tick();
        chk("b2b_not_yet", {31'd0, out_valid}, 32'd0);
        tick();
        chk("b2b_first_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_first_result", out_result, 32'h0F0FF0F0);
        chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        begin
            logic [15:0] cnt1;
            cnt1 = op_count;
            $display("op b2b cmd=2 -> res=%h", out_result);
            tick();
            chk("b2b_count", {16'd0, op_count}, {16'd0, cnt1 + 16'd1});
        end
        chk("b2b_valid_fall", {31'd0, out_valid}, 32'd0);
        chk("b2b_second_operandA", alu_operandA, 32'd1);
        chk("b2b_second_command", {29'd0, alu_command}, 32'd7);
        in_valid = 1'b0;
        repeat (SC - 1) tick();
        chk("b2b_second_not_yet", {31'd0, out_valid}, 32'd0);
        tick();
        chk("b2b_second_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_second_result", out_result, 32'd3);
        $display("op b2b cmd=7 -> res=%h", out_result);
        tick();

        // Reset in the middle of SETTLE drops the op.
        in_valid = 1'b1; in_opA = 32'hFF; in_opB = 32'h0F; in_cmd = 3'd4;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_operandA", alu_operandA, 32'd0);
        chk("mid_rst_command", {29'd0, alu_command}, 32'd0);
        chk("mid_rst_out_result", out_result, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_op_count", {16'd0, op_count}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mid_rst_no_valid", {31'd0, out_valid}, 32'd0);
        end
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
        end
        chk("post_rst_op_count", {16'd0, op_count}, 32'd0);
        $display("op reset mid-settle, count=%0d", op_count);
        run_vec('{32'd1, 32'd1, 3'd0, 32'd2, 1'b0, 1'b0, 1'b0});

        // Minimum latency and counter wrap on the narrow instance.
        for (int k = 0; k < 17; k++) begin
            logic [31:0] a;
            logic [3:0]  exp_cnt;
            a = 32'(k);
            exp_cnt = 4'(k + 1);
            w_in_valid = 1'b1; w_in_opA = a; w_in_opB = 32'h10; w_in_cmd = 3'd6;
            tick();
            w_in_valid = 1'b0;
            chk("wrap_not_yet", {31'd0, w_out_valid}, 32'd0);
            tick();
            chk("wrap_valid", {31'd0, w_out_valid}, 32'd1);
            chk("wrap_result", w_out_result, ~(a | 32'h10));
            tick();
            chk("wrap_count", {28'd0, w_op_count}, {28'd0, exp_cnt});
            $display("op wrap %0d NOR -> count=%0d", k, w_op_count);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Sequencing stage wrapped around the 32-bit ripple ALU.
- Upstream side: accepts one operation (operandA, operandB, 3-bit command) at a time on a valid/ready handshake and registers it onto the ALU input ports.
- Settle phase: holds the ALU inputs stable for a programmable number of clock cycles so the gate-delay ALU can finish propagating.
- Downstream side: captures result, carryout, zero and overflow into an output register and presents them on a valid/ready handshake.

Parameters:
- SETTLE_CYCLES, 4, clock edges between accepting an operation and sampling ALU outputs; legal range 1..255. SETTLE_CYCLES times the clock period must exceed worst-case ALU propagation.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream operation present
- in_ready  output  1  stage can accept an operation this cycle
- in_opA  input  32  operand A
- in_opB  input  32  operand B
- in_cmd  input  3  ALU command (0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR)
- alu_operandA  output  32  registered drive to ALU operandA
- alu_operandB  output  32  registered drive to ALU operandB
- alu_command  output  3  registered drive to ALU command
- alu_result  input  32  ALU result
- alu_carryout  input  1  ALU carryout
- alu_zero  input  1  ALU zero
- alu_overflow  input  1  ALU overflow
- out_valid  output  1  captured result available
- out_ready  input  1  downstream consumes result
- out_result  output  32  captured result
- out_carryout  output  1  captured carryout
- out_zero  output  1  captured zero
- out_overflow  output  1  captured overflow
- out_cmd  output  3  command that produced the captured result
- busy  output  1  state is not IDLE
- op_count  output  CNT_W  completed output handshakes, wraps

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE, settle counter 0, op_count 0, busy 0.
  - All registered outputs 0: alu_operandA/B, alu_command (ADD), out_valid, out_result, out_carryout, out_zero, out_overflow, out_cmd.
- Reset is honoured immediately in any state, including mid-SETTLE and DONE. Any in-flight operation is dropped and is not counted.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SETTLE: in_ready=0, out_valid=0. Counter decrements each edge.
  - DONE: out_valid=1; in_ready=out_ready (combinational).
- Accept = in_valid & in_ready at a rising edge.
  - On accept: in_opA/in_opB/in_cmd are loaded into the alu_* registers, counter is loaded with SETTLE_CYCLES-1, and state goes to SETTLE.
- SETTLE, counter==0 at an edge:
  - Capture alu_result/carryout/zero/overflow into the out_* registers.
  - out_cmd <= alu_command; state goes to DONE.
- Latency: out_valid rises exactly SETTLE_CYCLES edges after the accept edge. With SETTLE_CYCLES=1, capture happens on the first edge after accept.
- DONE, out_ready=0: all out_* and alu_* registers hold indefinitely; in_ready=0.
- DONE, out_ready=1, in_valid=0: output handshake completes, op_count increments, state goes to IDLE, out_valid falls.
- DONE, out_ready=1, in_valid=1 (simultaneous): output handshake and accept happen on the same edge.
  - op_count increments; the new operation loads; state goes to SETTLE.
  - No idle bubble. Sustained throughput is one operation per SETTLE_CYCLES+1 cycles.
- alu_* registers change only on accept. They are stable throughout SETTLE and DONE.
- out_* registers change only at the capture edge; they keep their last values in IDLE.
- Flags are passed through unmodified; the ALU itself zeroes carryout/overflow for non-ADD/SUB commands.
- op_count wraps from 2^CNT_W-1 to 0 with no saturation or flag.
- in_valid in SETTLE is ignored (not accepted). Upstream must hold it and its data until in_ready.

Test Plan:
- Reset, then ADD 5+7 (SETTLE_CYCLES=4, out_ready=1) -> alu_operandA=5 on the accept edge; out_valid high at edge 4; out_result=12, zero=0, carryout=0, overflow=0, out_cmd=0; op_count=1 next edge.
- SUB 3-3, then ADD 0x7FFFFFFF+1 -> SUB gives result 0, zero=1, carryout=1, overflow=0; ADD gives result 0x80000000, overflow=1, carryout=0.
- Backpressure: SLT 0xFFFFFFFF,1 with out_ready=0 for 10 cycles and in_valid held high -> result 1 held stable, in_ready=0 throughout, alu_* unchanged, op_count unchanged until out_ready rises.
- Back-to-back: queue XOR 0xF0F0F0F0^0xFFFF0000 then OR 1|2 with in_valid and out_ready held high -> results 0x0F0FF0F0 then 3; second accept on the same edge as the first output handshake; outputs 5 cycles apart.
- Reset mid-SETTLE: accept AND, assert reset_n=0 at edge 2 -> all outputs 0 immediately, out_valid never rises, op_count=0; a fresh ADD 1+1 afterwards returns 2.
- Wrap and minimum latency: CNT_W=4, SETTLE_CYCLES=1, run 17 NOR ops -> each out_valid one edge after accept; op_count reads 15 after 15 ops, 0 after 16, 1 after 17.
